// File: rtl/ours_bdg_x2p_pkg.sv
// Shared types for the x2p bridge: APB request/response payloads,
// arbiter state encoding and the default watchdog limit.
package ours_bdg_x2p_pkg;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  typedef enum logic [0:0] {
    ST_ARB_IDLE  = 1'b0,
    ST_ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_TIMEOUT_DEF = 256;

endpackage

// File: rtl/ours_bdg_x2p_rr_pick.sv
// Combinational round-robin picker: returns the first set candidate at or
// above rr_ptr, wrapping modulo N.
module ours_bdg_x2p_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the farthest slot back to rr_ptr so the closest candidate wins last.
  always_comb begin
    int sum_s;
    int pos_s;
    idx   = '0;
    any   = 1'b0;
    sum_s = 0;
    pos_s = 0;
    for (int i = N - 1; i >= 0; i--) begin
      sum_s = int'(rr_ptr) + i;
      pos_s = (sum_s >= N) ? (sum_s - N) : sum_s;
      if (cand[IDX_W'(pos_s)]) begin
        idx = IDX_W'(pos_s);
        any = 1'b1;
      end else begin
        idx = idx;
        any = any;
      end
    end
  end

endmodule

// File: rtl/ours_bdg_x2p_parb.sv
// Round-robin arbiter sharing the pdec APB sequencer among N_REQ requesters,
// holding each grant until its response is accepted, with a sticky watchdog.
module ours_bdg_x2p_parb
  import ours_bdg_x2p_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF,
  parameter int IDX_W   = $clog2(N_REQ)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  apb_req_t          req_t [N_REQ],
  output logic [N_REQ-1:0]  resp_valid,
  input  logic [N_REQ-1:0]  resp_ready,
  output apb_resp_t         resp_t,
  output logic              arb_pdec_preq_valid,
  input  logic              pdec_arb_preq_ready,
  output apb_req_t          arb_pdec_preq_t,
  input  logic              pdec_arb_presp_valid,
  output logic              arb_pdec_presp_ready,
  input  apb_resp_t         pdec_arb_presp_t,
  input  logic [N_REQ-1:0]  req_en,
  output logic              timeout_err,
  output logic [IDX_W-1:0]  timeout_idx,
  input  logic              timeout_clr
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_e       state_r, state_s;
  logic [IDX_W-1:0] gnt_idx_r, gnt_idx_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
  logic [WD_W-1:0]  wd_cnt_r, wd_cnt_s;
  logic             timeout_err_r;
  logic [IDX_W-1:0] timeout_idx_r;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             complete_s;
  logic             wd_fire_s;

  ours_bdg_x2p_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .cand   (req_valid & req_en),
    .rr_ptr (rr_ptr_r),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Next-state, watchdog and steering of both channels for the granted requester.
  always_comb begin
    state_s              = state_r;
    gnt_idx_s            = gnt_idx_r;
    rr_ptr_s             = rr_ptr_r;
    wd_cnt_s             = wd_cnt_r;
    wd_fire_s            = 1'b0;
    req_ready            = '0;
    resp_valid           = '0;
    arb_pdec_preq_valid  = 1'b0;
    arb_pdec_preq_t      = '0;
    arb_pdec_presp_ready = 1'b0;
    resp_t               = pdec_arb_presp_t;
    complete_s           = pdec_arb_presp_valid & resp_ready[gnt_idx_r];
    case (state_r)
      ST_ARB_IDLE: begin
        if (pick_any_s) begin
          state_s   = ST_ARB_GRANT;
          gnt_idx_s = pick_idx_s;
          wd_cnt_s  = '0;
        end else begin
          state_s   = ST_ARB_IDLE;
        end
      end
      ST_ARB_GRANT: begin
        arb_pdec_preq_valid   = req_valid[gnt_idx_r];
        arb_pdec_preq_t       = req_t[gnt_idx_r];
        arb_pdec_presp_ready  = resp_ready[gnt_idx_r];
        req_ready[gnt_idx_r]  = pdec_arb_preq_ready;
        resp_valid[gnt_idx_r] = pdec_arb_presp_valid;
        wd_fire_s = (wd_cnt_r == WD_W'(TIMEOUT - 1)) & ~complete_s;
        if (wd_cnt_r != WD_W'(TIMEOUT)) begin
          wd_cnt_s = wd_cnt_r + WD_W'(1);
        end else begin
          wd_cnt_s = wd_cnt_r;
        end
        if (complete_s) begin
          state_s  = ST_ARB_IDLE;
          rr_ptr_s = (gnt_idx_r == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_r + IDX_W'(1);
        end else begin
          state_s  = ST_ARB_GRANT;
        end
      end
      default: begin
        state_s = ST_ARB_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r   <= ST_ARB_IDLE;
      gnt_idx_r <= '0;
      rr_ptr_r  <= '0;
      wd_cnt_r  <= '0;
    end else begin
      state_r   <= state_s;
      gnt_idx_r <= gnt_idx_s;
      rr_ptr_r  <= rr_ptr_s;
      wd_cnt_r  <= wd_cnt_s;
    end
  end

  // Sticky watchdog flag; a clear in the same cycle beats a new set.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      timeout_err_r <= 1'b0;
      timeout_idx_r <= '0;
    end else if (timeout_clr) begin
      timeout_err_r <= 1'b0;
      timeout_idx_r <= '0;
    end else if (wd_fire_s && !timeout_err_r) begin
      timeout_err_r <= 1'b1;
      timeout_idx_r <= gnt_idx_r;
    end else begin
      timeout_err_r <= timeout_err_r;
      timeout_idx_r <= timeout_idx_r;
    end
  end

  assign timeout_err = timeout_err_r;
  assign timeout_idx = timeout_idx_r;

endmodule

// File: tb/tb_ours_bdg_x2p_parb.sv
// Self-checking bench for ours_bdg_x2p_parb: requester and pdec models driven
// once per cycle, expected grant order kept in a scoreboard queue.
module tb_ours_bdg_x2p_parb;
  import ours_bdg_x2p_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int IW = 2;

  logic           aclk = 1'b0;
  logic           areset;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready, req_en;
  apb_req_t       req_t_a [N];
  apb_resp_t      resp_t;
  logic           arb_pdec_preq_valid, pdec_arb_preq_ready;
  apb_req_t       arb_pdec_preq_t;
  logic           pdec_arb_presp_valid, arb_pdec_presp_ready;
  apb_resp_t      pdec_arb_presp_t;
  logic           timeout_err, timeout_clr;
  logic [IW-1:0]  timeout_idx;

  int             n_chk = 0;
  int             n_pass = 0;
  int             pend [N];
  int             seq;
  int             lat;
  int             mcnt;
  int             psel_seen;
  logic [N-1:0]   hs_req;
  logic           prev_done;
  int             sb_q [$];

  always #5 aclk = ~aclk;

  ours_bdg_x2p_parb #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_t                (req_t_a),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .resp_t               (resp_t),
    .arb_pdec_preq_valid  (arb_pdec_preq_valid),
    .pdec_arb_preq_ready  (pdec_arb_preq_ready),
    .arb_pdec_preq_t      (arb_pdec_preq_t),
    .pdec_arb_presp_valid (pdec_arb_presp_valid),
    .arb_pdec_presp_ready (arb_pdec_presp_ready),
    .pdec_arb_presp_t     (pdec_arb_presp_t),
    .req_en               (req_en),
    .timeout_err          (timeout_err),
    .timeout_idx          (timeout_idx),
    .timeout_clr          (timeout_clr)
  );

  // One clock: requesters update, then the pdec model, then the scoreboard at negedge.
  task automatic tick();
    logic        psel;
    logic [N-1:0] oh;
    logic [N-1:0] hs;
    int          e;
    @(posedge aclk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (hs_req[r]) begin
        req_valid[r] = 1'b0;
        pend[r] = pend[r] - 1;
      end
      if (!req_valid[r] && pend[r] > 0) begin
        seq = seq + 1;
        req_valid[r] = 1'b1;
        req_t_a[r].paddr = 32'(r * 256 + seq * 4);
      end
    end
    #1;
    psel = arb_pdec_preq_valid & arb_pdec_presp_ready;
    pdec_arb_preq_ready  = 1'b0;
    pdec_arb_presp_valid = 1'b0;
    if (psel) begin
      psel_seen = psel_seen + 1;
      if (mcnt == lat) begin
        pdec_arb_preq_ready      = 1'b1;
        pdec_arb_presp_valid     = 1'b1;
        pdec_arb_presp_t.prdata  = arb_pdec_preq_t.paddr ^ 32'h5A5A_0000;
        pdec_arb_presp_t.pslverr = 1'b0;
        mcnt = 0;
      end else begin
        mcnt = mcnt + 1;
      end
    end else begin
      mcnt = 0;
    end
    @(negedge aclk);
    if (prev_done) begin
      n_chk++;
      if (arb_pdec_preq_valid !== 1'b0) $display("FAIL bubble: preq_valid=%b required 0", arb_pdec_preq_valid);
      else n_pass++;
    end
    hs = resp_valid & resp_ready;
    if (|hs) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: resp_valid=%b with empty scoreboard", resp_valid);
      end else begin
        e = sb_q.pop_front();
        oh = '0;
        oh[e] = 1'b1;
        n_chk++;
        if (resp_valid !== oh) $display("FAIL sb_resp_valid: got %b required %b", resp_valid, oh);
        else n_pass++;
        n_chk++;
        if (req_ready !== oh) $display("FAIL sb_req_ready: got %b required %b", req_ready, oh);
        else n_pass++;
        n_chk++;
        if (resp_t.prdata !== (req_t_a[e].paddr ^ 32'h5A5A_0000))
          $display("FAIL sb_data: got %h required %h", resp_t.prdata, req_t_a[e].paddr ^ 32'h5A5A_0000);
        else n_pass++;
      end
    end
    prev_done = |hs;
    hs_req = req_valid & req_ready;
  endtask

  task automatic run_until_done(input string name);
    int c;
    c = 0;
    while (sb_q.size() > 0 && c < 300) begin
      tick();
      c++;
    end
    n_chk++;
    if (c >= 300) $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, sb_q.size());
    else n_pass++;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int r = 0; r < N; r++) pend[r] = 0;
    req_valid = '0;
    resp_ready = '1;
    req_en = '1;
    timeout_clr = 1'b0;
    pdec_arb_preq_ready = 1'b0;
    pdec_arb_presp_valid = 1'b0;
    lat = 2;
    mcnt = 0;
    psel_seen = 0;
    hs_req = '0;
    prev_done = 1'b0;
    sb_q.delete();
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({req_ready, resp_valid, arb_pdec_preq_valid, arb_pdec_presp_ready, timeout_err, timeout_idx} !== '0)
      $display("FAIL reset_outputs: req_ready=%b resp_valid=%b preq_valid=%b presp_ready=%b err=%b idx=%0d required all 0",
               req_ready, resp_valid, arb_pdec_preq_valid, arb_pdec_presp_ready, timeout_err, timeout_idx);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    pend[2] = 1;
    sb_q.push_back(2);
    tick();
    n_chk++;
    if (arb_pdec_preq_valid !== 1'b0) $display("FAIL single_c0: preq_valid=%b required 0", arb_pdec_preq_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (arb_pdec_preq_valid !== 1'b1) $display("FAIL single_c1: preq_valid=%b required 1", arb_pdec_preq_valid);
    else n_pass++;
    n_chk++;
    if (arb_pdec_preq_t.paddr !== req_t_a[2].paddr)
      $display("FAIL single_payload: got %h required %h", arb_pdec_preq_t.paddr, req_t_a[2].paddr);
    else n_pass++;
    run_until_done("single");
    // rr_ptr should now be 3, so requester 3 beats requester 0
    pend[0] = 1;
    pend[3] = 1;
    sb_q.push_back(3);
    sb_q.push_back(0);
    run_until_done("single_rrptr");
  endtask

  task automatic test_back_to_back();
    do_reset();
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2); sb_q.push_back(3); sb_q.push_back(0);
    run_until_done("b2b");
  endtask

  task automatic test_req_en();
    do_reset();
    req_en = 4'b1011;
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(3); sb_q.push_back(0);
    run_until_done("req_en");
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if (arb_pdec_preq_valid !== 1'b0 || req_valid[2] !== 1'b1)
        $display("FAIL req_en_idle: preq_valid=%b req_valid2=%b required 0 and 1", arb_pdec_preq_valid, req_valid[2]);
      else n_pass++;
    end
    pend[2] = 0;
    req_valid[2] = 1'b0;
    req_en = 4'b1111;
  endtask

  task automatic test_resp_hold();
    do_reset();
    resp_ready = 4'b1101;
    pend[1] = 1;
    sb_q.push_back(1);
    tick();
    tick();
    req_en[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++;
      if (arb_pdec_presp_ready !== 1'b0 || arb_pdec_preq_valid !== 1'b1 || req_ready !== 4'b0000)
        $display("FAIL hold_grant: presp_ready=%b preq_valid=%b req_ready=%b required 0 1 0000",
                 arb_pdec_presp_ready, arb_pdec_preq_valid, req_ready);
      else n_pass++;
    end
    n_chk++;
    if (psel_seen !== 0) $display("FAIL hold_psel: psel cycles %0d required 0", psel_seen);
    else n_pass++;
    resp_ready[1] = 1'b1;
    run_until_done("hold");
    req_en[1] = 1'b1;
  endtask

  task automatic test_timeout();
    do_reset();
    lat = 22;
    pend[3] = 1;
    sb_q.push_back(3);
    tick();
    for (int k = 0; k <= 17; k++) begin
      tick();
      if (k == 15) begin
        n_chk++;
        if (timeout_err !== 1'b0) $display("FAIL wd_early: timeout_err=%b required 0 at grant cycle 15", timeout_err);
        else n_pass++;
      end else if (k == 16) begin
        n_chk++;
        if (timeout_err !== 1'b1 || timeout_idx !== 2'd3)
          $display("FAIL wd_fire: err=%b idx=%0d required 1 and 3", timeout_err, timeout_idx);
        else n_pass++;
      end else if (k == 17) begin
        n_chk++;
        if (arb_pdec_preq_valid !== 1'b1) $display("FAIL wd_held: preq_valid=%b required 1", arb_pdec_preq_valid);
        else n_pass++;
      end else begin
      end
    end
    run_until_done("wd");
    n_chk++;
    if (timeout_err !== 1'b1) $display("FAIL wd_sticky: timeout_err=%b required 1", timeout_err);
    else n_pass++;
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    n_chk++;
    if (timeout_err !== 1'b0 || timeout_idx !== 2'd0)
      $display("FAIL wd_clear: err=%b idx=%0d required 0 and 0", timeout_err, timeout_idx);
    else n_pass++;
  endtask

  task automatic test_midreset();
    do_reset();
    pend[1] = 1;
    sb_q.push_back(1);
    run_until_done("mid_pre");
    pend[2] = 1;
    tick();
    tick();
    tick();
    #2;
    areset = 1'b1;
    #1;
    n_chk++;
    if ({req_ready, resp_valid, arb_pdec_preq_valid, arb_pdec_presp_ready} !== '0)
      $display("FAIL midreset_outputs: req_ready=%b resp_valid=%b preq_valid=%b presp_ready=%b required all 0",
               req_ready, resp_valid, arb_pdec_preq_valid, arb_pdec_presp_ready);
    else n_pass++;
    for (int r = 0; r < N; r++) pend[r] = 0;
    req_valid = '0;
    pdec_arb_preq_ready = 1'b0;
    pdec_arb_presp_valid = 1'b0;
    mcnt = 0;
    hs_req = '0;
    prev_done = 1'b0;
    sb_q.delete();
    @(posedge aclk);
    #3;
    areset = 1'b0;
    // rr_ptr restarts at 0, so requester 1 wins over 3
    pend[1] = 1;
    pend[3] = 1;
    sb_q.push_back(1);
    sb_q.push_back(3);
    run_until_done("midreset_post");
  endtask

  initial begin
    for (int r = 0; r < N; r++) req_t_a[r] = '0;
    pdec_arb_presp_t = '0;
    seq = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_req_en();
    test_resp_hold();
    test_timeout();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
